// File: rtl/sysid_pkg.sv
// Shared register map for the sysid slave: offsets, CTRL bits, CAPS layout and defaults.
package sysid_pkg;

  localparam int OFS_ID        = 0;
  localparam int OFS_TIMESTAMP = 1;
  localparam int OFS_CAPS      = 2;
  localparam int OFS_UPTIME_LO = 3;
  localparam int OFS_UPTIME_HI = 4;
  localparam int OFS_CTRL      = 5;
  localparam int OFS_SCRATCH0  = 6;

  localparam int CTRL_CLEAR_BIT  = 0;
  localparam int CTRL_FREEZE_BIT = 1;

  localparam int CAPS_VERSION_LSB = 0;
  localparam int CAPS_NSCR_LSB    = 8;

  localparam logic [31:0] DEFAULT_SYS_ID  = 32'h5244_4A22;
  localparam logic [7:0]  DEFAULT_VERSION = 8'd2;

  function automatic logic [31:0] caps_word(input logic [7:0] nscr, input logic [7:0] ver);
    logic [31:0] w;
    w = '0;
    w[CAPS_NSCR_LSB +: 8]    = nscr;
    w[CAPS_VERSION_LSB +: 8] = ver;
    return w;
  endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// 64-bit free-running uptime counter with clear/freeze and a high-word snapshot.
module sysid_uptime_counter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        freeze,
  input  logic        snap,
  output logic [63:0] count,
  output logic [31:0] snap_hi
);

  logic [63:0] count_nxt;

  // clear beats freeze so a combined clear+freeze parks the counter at 0
  assign count_nxt = clear  ? 64'd0 :
                     freeze ? count : count + 64'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      snap_hi <= '0;
    end else begin
      count <= count_nxt;
      if (snap) snap_hi <= count[63:32];
    end
  end

endmodule

// File: rtl/sysid_regs.sv
// Avalon-MM system-ID slave: RO identity words, uptime counter, CTRL and scratch bank.
module sysid_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYS_ID        = DEFAULT_SYS_ID,
  parameter logic [31:0] TIMESTAMP     = 32'h0,
  parameter logic [7:0]  VERSION       = DEFAULT_VERSION,
  parameter int          NUM_SCRATCH   = 4,
  parameter int          ADDR_WIDTH    = 4,
  parameter logic [31:0] SCRATCH_RESET = 32'h0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  input  logic [3:0]            byteenable,
  output logic [31:0]           readdata,
  output logic                  readdatavalid
);

  logic [31:0] addr32;
  assign addr32 = 32'(address);

  logic ctrl_wr, ctrl_clear, ctrl_freeze;
  assign ctrl_wr    = write && (addr32 == 32'(OFS_CTRL)) && byteenable[0];
  assign ctrl_clear = ctrl_wr && writedata[CTRL_CLEAR_BIT];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     ctrl_freeze <= 1'b0;
    else if (ctrl_wr) ctrl_freeze <= writedata[CTRL_FREEZE_BIT];
  end

  logic [63:0] uptime;
  logic [31:0] snap_hi;
  logic        snap;
  assign snap = read && (addr32 == 32'(OFS_UPTIME_LO));

  sysid_uptime_counter u_uptime (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (ctrl_clear),
    .freeze  (ctrl_freeze),
    .snap    (snap),
    .count   (uptime),
    .snap_hi (snap_hi)
  );

  // live high word is only visible through the snapshot
  logic unused_uptime_hi;
  assign unused_uptime_hi = ^uptime[63:32];

  logic [NUM_SCRATCH-1:0][31:0] scratch;

  for (genvar i = 0; i < NUM_SCRATCH; i++) begin : g_scr
    logic sel;
    assign sel = write && (addr32 == 32'(OFS_SCRATCH0 + i));
    for (genvar b = 0; b < 4; b++) begin : g_byte
      logic [7:0] q;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                 q <= SCRATCH_RESET[8*b +: 8];
        else if (sel && byteenable[b]) q <= writedata[8*b +: 8];
      end
      assign scratch[i][8*b +: 8] = q;
    end
  end

  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    case (addr32)
      32'(OFS_ID):        rd_mux = SYS_ID;
      32'(OFS_TIMESTAMP): rd_mux = TIMESTAMP;
      32'(OFS_CAPS):      rd_mux = caps_word(8'(NUM_SCRATCH), VERSION);
      32'(OFS_UPTIME_LO): rd_mux = uptime[31:0];
      32'(OFS_UPTIME_HI): rd_mux = snap_hi;
      32'(OFS_CTRL):      rd_mux[CTRL_FREEZE_BIT] = ctrl_freeze;
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++)
          if (addr32 == 32'(OFS_SCRATCH0 + i)) rd_mux = scratch[i];
      end
    endcase
  end

  // readdata samples pre-write state, so a colliding write is not visible to the read
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_sysid_regs.sv
// Directed bench for sysid_regs with hand-computed expectations.
module tb_sysid_regs;
  import sysid_pkg::*;

  localparam logic [31:0] TS = 32'h6512_3456;
  localparam logic [31:0] SR = 32'hA5A5_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic [63:0] pre_v;

  int n_chk = 0;
  int n_fail = 0;

  sysid_regs #(
    .TIMESTAMP     (TS),
    .SCRATCH_RESET (SR)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    @(negedge clock);
    read = 1'b1; address = a;
    @(posedge clock); #1;
    read = 1'b0;
    chk({tag, " vld"}, 32'(readdatavalid), 32'd1);
    chk(tag, readdata, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clock);
    write = 1'b1; address = a; writedata = d; byteenable = be;
    @(posedge clock); #1;
    write = 1'b0; byteenable = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
  endtask

  // bench hook: loads the counter through its next-state net for one edge
  task preload(input logic [63:0] v);
    pre_v = v;
    @(negedge clock);
    force dut.u_uptime.count_nxt = pre_v;
    @(posedge clock); #1;
    release dut.u_uptime.count_nxt;
  endtask

  initial begin
    #12;
    chk("reset rdata", readdata, 32'h0);
    chk("reset rvld", 32'(readdatavalid), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    rd(4'(OFS_UPTIME_LO), 32'd1, "uptime first");
    rd(4'(OFS_ID), 32'h5244_4A22, "id");
    rd(4'(OFS_TIMESTAMP), TS, "timestamp");
    rd(4'(OFS_CAPS), 32'h0000_0402, "caps");
    @(posedge clock); #1;
    chk("rvld drop", 32'(readdatavalid), 32'd0);
    chk("rdata hold", readdata, 32'h0000_0402);
    rd(4'(OFS_SCRATCH0), SR, "scratch reset");
    rd(4'(OFS_CTRL), 32'h0, "ctrl reset");
    rd(4'(OFS_UPTIME_HI), 32'h0, "hi reset");

    // scratch byte lanes
    wr(4'd6, 32'hDEAD_BEEF, 4'hF);
    rd(4'd6, 32'hDEAD_BEEF, "scr full");
    wr(4'd6, 32'h0000_1234, 4'b0011);
    rd(4'd6, 32'hDEAD_1234, "scr be0011");
    wr(4'd6, 32'hFFFF_FFFF, 4'b0000);
    rd(4'd6, 32'hDEAD_1234, "scr be0000");
    wr(4'd6, 32'h00AB_0000, 4'b0100);
    rd(4'd6, 32'hDEAB_1234, "scr be0100");

    // colliding read+write returns the pre-write value
    @(negedge clock);
    read = 1'b1; write = 1'b1; address = 4'd6; writedata = 32'h1111_1111; byteenable = 4'hF;
    @(posedge clock); #1;
    read = 1'b0; write = 1'b0; byteenable = '0;
    chk("rw vld", 32'(readdatavalid), 32'd1);
    chk("rw old", readdata, 32'hDEAB_1234);
    rd(4'd6, 32'h1111_1111, "rw new");

    // RO and unmapped offsets
    wr(4'(OFS_CAPS), 32'hFFFF_FFFF, 4'hF);
    rd(4'(OFS_CAPS), 32'h0000_0402, "caps ro");
    wr(4'd15, 32'hFFFF_FFFF, 4'hF);
    rd(4'd15, 32'h0, "ofs15");
    rd(4'd10, 32'h0, "ofs10");

    // back-to-back reads
    rd(4'd0, 32'h5244_4A22, "b2b0");
    rd(4'd1, TS, "b2b1");
    rd(4'd2, 32'h0000_0402, "b2b2");
    rd(4'd6, 32'h1111_1111, "b2b6");
    rd(4'd15, 32'h0, "b2b15");

    // CTRL ignores lanes other than byte 0
    wr(4'(OFS_CTRL), 32'h2, 4'b1110);
    rd(4'(OFS_CTRL), 32'h0, "ctrl be");

    // clear+freeze parks at 0, release counts again
    wr(4'(OFS_CTRL), 32'h3, 4'hF);
    rd(4'(OFS_UPTIME_LO), 32'h0, "frz lo0");
    idle(20);
    rd(4'(OFS_UPTIME_LO), 32'h0, "frz lo20");
    rd(4'(OFS_CTRL), 32'h2, "ctrl frz");
    wr(4'(OFS_CTRL), 32'h0, 4'hF);
    idle(1);
    rd(4'(OFS_UPTIME_LO), 32'h1, "unfrz lo");
    rd(4'(OFS_CTRL), 32'h0, "ctrl zero");

    // snapshot is latched at the LO read, not live
    wr(4'(OFS_CTRL), 32'h2, 4'hF);
    preload(64'h0000_0005_FFFF_FFFF);
    wr(4'(OFS_CTRL), 32'h0, 4'hF);
    rd(4'(OFS_UPTIME_LO), 32'hFFFF_FFFF, "snap lo");
    idle(10);
    rd(4'(OFS_UPTIME_HI), 32'h5, "snap hi stale");
    rd(4'(OFS_UPTIME_LO), 32'hB, "snap lo2");
    rd(4'(OFS_UPTIME_HI), 32'h6, "snap hi2");

    // 64-bit wrap
    wr(4'(OFS_CTRL), 32'h2, 4'hF);
    preload(64'hFFFF_FFFF_FFFF_FFFE);
    wr(4'(OFS_CTRL), 32'h0, 4'hF);
    rd(4'(OFS_UPTIME_LO), 32'hFFFF_FFFE, "wrap lo");
    rd(4'(OFS_UPTIME_HI), 32'hFFFF_FFFF, "wrap hi");
    rd(4'(OFS_UPTIME_LO), 32'h0, "wrap lo0");
    rd(4'(OFS_UPTIME_HI), 32'h0, "wrap hi0");

    // clear while running
    wr(4'(OFS_CTRL), 32'h1, 4'hF);
    rd(4'(OFS_UPTIME_LO), 32'h0, "clr lo0");
    rd(4'(OFS_UPTIME_LO), 32'h1, "clr lo1");
    rd(4'(OFS_CTRL), 32'h0, "clr reads0");

    // reset in the middle of a read
    wr(4'd7, 32'h1234_5678, 4'hF);
    rd(4'd7, 32'h1234_5678, "scr1");
    @(negedge clock);
    read = 1'b1; address = 4'd7;
    #2 reset_n = 1'b0;
    #1 chk("mid rst rdata", readdata, 32'h0);
    @(posedge clock); #1;
    read = 1'b0;
    chk("mid rst rvld", 32'(readdatavalid), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    rd(4'(OFS_UPTIME_LO), 32'd1, "rst restart");
    rd(4'd7, SR, "rst scr1");
    rd(4'(OFS_CTRL), 32'h0, "rst ctrl");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
